// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port owner of the background framebuffer BRAM.
// Shares the port between scanout reads (active video), a hardware clear
// engine and a pixel-write FIFO (both only while blanking).
// Optional build macro FB_DROP_COUNT_EN adds a saturating drop_count output
// counting out-of-range write requests.
module fb_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              blank_in,
  input  logic [10:0]       drawX,
  input  logic [10:0]       drawY,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_x,
  input  logic [10:0]       wr_y,
  input  logic [11:0]       wr_color,
  input  logic              clear_req,
  input  logic [11:0]       clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_din,
  output logic              mem_we,
  input  logic [11:0]       mem_dout,
`ifdef FB_DROP_COUNT_EN
  output logic [15:0]       drop_count,
`endif
  output logic [11:0]       background
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [10:0] x, input logic [10:0] y);
    return ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));
  endfunction

  state_t            state_q;
  logic              clear_busy_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [11:0]       clr_color_q;

  logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [11:0]       fifo_color_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [11:0]       mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              rd_issue, rd_d1_q, rd_d2_q;

  logic in_range, push_any, push_st, pop;

  assign wr_ready = (count_q != FULL_CNT);
  assign in_range = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign push_any = wr_valid && wr_ready;
  assign push_st  = push_any && in_range;

  // Port arbitration: scanout, then clear, then FIFO; otherwise hold the address.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    rd_issue   = 1'b0;
    pop        = 1'b0;
    if (!blank_in) begin
      rd_issue   = 1'b1;
      mem_addr_d = pix_addr(drawX, drawY);
    end else if (clear_busy_q) begin
      mem_we_d   = 1'b1;
      mem_addr_d = clr_ptr_q;
      mem_din_d  = clr_color_q;
    end else if (count_q != '0) begin
      pop        = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = fifo_addr_q[rd_ptr_q];
      mem_din_d  = fifo_color_q[rd_ptr_q];
    end
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_st, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear engine FSM; clr_ptr only advances on cycles it owns the port.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clear_busy_q <= 1'b0;
      clr_ptr_q    <= '0;
      clr_color_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q      <= S_CLEAR;
            clear_busy_q <= 1'b1;
            clr_ptr_q    <= '0;
            clr_color_q  <= clear_color;
          end
        end
        S_CLEAR: begin
          if (blank_in) begin
            if (clr_ptr_q == LAST_PIX) begin
              state_q      <= S_IDLE;
              clear_busy_q <= 1'b0;
            end else begin
              clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; the address is resolved at push so the pop path stays short.
  always_ff @(posedge pixel_clk) begin
    if (push_st) begin
      fifo_addr_q[wr_ptr_q]  <= pix_addr(wr_x, wr_y);
      fifo_color_q[wr_ptr_q] <= wr_color;
    end
  end

  // FIFO pointers and count.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_st) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Registered memory port and the read-issued delay line.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      rd_d1_q    <= 1'b0;
      rd_d2_q    <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      rd_d1_q    <= rd_issue;
      rd_d2_q    <= rd_d1_q;
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of accepted-but-dropped out-of-range requests.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (push_any && !in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // The BRAM output register is the second pipeline stage: mem_dout and
  // rd_d2_q are both register outputs aligned two cycles after drawX/drawY.
  assign background = rd_d2_q ? mem_dout : 12'h000;

  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter with a reduced frame height (640x16) so full clears
// stay short. Writes are tracked by a scoreboard queue of {addr, data}.
module tb_fb_arbiter;

  localparam int TB_H = 640;
  localparam int TB_V = 16;
  localparam int NPIX = TB_H * TB_V;
  localparam int AW   = 19;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic          blank_in;
  logic [10:0]   drawX, drawY;
  logic          wr_valid;
  logic          wr_ready;
  logic [10:0]   wr_x, wr_y;
  logic [11:0]   wr_color;
  logic          clear_req;
  logic [11:0]   clear_color;
  logic          clear_busy;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_din;
  logic          mem_we;
  logic [11:0]   mem_dout;
  logic [11:0]   background;
`ifdef FB_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  fb_arbiter #(.H_RES(TB_H), .V_RES(TB_V), .ADDR_W(AW), .FIFO_DEPTH(16)) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .blank_in    (blank_in),
    .drawX       (drawX),
    .drawY       (drawY),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
`ifdef FB_DROP_COUNT_EN
    .drop_count  (drop_count),
`endif
    .background  (background)
  );

  always #5 pixel_clk = ~pixel_clk;

  // BRAM model: write-first not needed, 1-cycle read latency.
  logic [11:0] ram [0:(1<<AW)-1];
  always @(posedge pixel_clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_drop   = 0;
  int wr_cnt   = 0;
  int busy_cnt = 0;
  bit sb_en    = 1'b1;
  logic [30:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs as seen by the DUT at the previous rising edge.
  logic        blank_prev = 1'b1;
  logic        rst_prev   = 1'b1;
  logic [10:0] dx_prev = '0, dy_prev = '0;
  always @(posedge pixel_clk) begin
    blank_prev <= blank_in;
    rst_prev   <= rst;
    dx_prev    <= drawX;
    dy_prev    <= drawY;
  end

  // Memory-port monitor: writes only during blanking, in scoreboard order;
  // active video always issues a read at the scan address.
  always @(negedge pixel_clk) begin
    if (clear_busy) busy_cnt++;
    if (mem_we) begin
      wr_cnt++;
      chk("we_in_blank", 32'(blank_prev), 32'd1);
      if (sb_en) begin
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("wr_addr_data", {1'b0, mem_addr, mem_din}, 32'(exp_q.pop_front()));
      end
    end
    if (!blank_prev && !rst_prev) begin
      chk("rd_we", 32'(mem_we), 32'd0);
      chk("rd_addr", 32'(mem_addr), 32'(int'(dy_prev) * TB_H + int'(dx_prev)));
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic send(input logic [10:0] x, input logic [10:0] y, input logic [11:0] c);
    int n = 0;
    wr_valid = 1'b1; wr_x = x; wr_y = y; wr_color = c;
    while (!wr_ready && n < 500) begin tick(); n++; end
    chk("send_accept", 32'(wr_ready), 32'd1);
    if (wr_ready) begin
      if (int'(x) < TB_H && int'(y) < TB_V) exp_q.push_back({AW'(int'(y) * TB_H + int'(x)), c});
      else n_drop++;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 12'h000;
    rst = 1'b1; blank_in = 1'b1; drawX = '0; drawY = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_req = 1'b0; clear_color = '0;

    // reset values
    tick();
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_bg", 32'(background), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy2", 32'(clear_busy), 32'd0);

    // scanout latency
    send(11'd3, 11'd2, 12'hABC);
    send(11'd4, 11'd2, 12'h123);
    wait_drain("drain_preload");
    blank_in = 1'b0; drawX = 11'd3; drawY = 11'd2;
    tick();
    chk("scan_addr", 32'(mem_addr), 32'd1283);
    drawX = 11'd4;
    tick();
    chk("scan_bg0", 32'(background), 32'hABC);
    blank_in = 1'b1;
    tick();
    chk("scan_bg1", 32'(background), 32'h123);
    tick();
    chk("scan_bg_blank", 32'(background), 32'd0);

    // write waits for blanking
    blank_in = 1'b0; drawX = '0; drawY = '0;
    send(11'd10, 11'd5, 12'hF00);
    repeat (5) tick();
    chk("arb_hold_we", 32'(mem_we), 32'd0);
    blank_in = 1'b1;
    tick();
    chk("arb_we", 32'(mem_we), 32'd1);
    chk("arb_addr", 32'(mem_addr), 32'd3210);
    chk("arb_din", 32'(mem_din), 32'hF00);
    wait_drain("drain_arb");

    // FIFO full, backpressure, then drops
    blank_in = 1'b0; drawX = 11'd20; drawY = 11'd1;
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", 32'(wr_ready), 32'd1);
      send(11'(i), 11'd7, 12'h100 + 12'(i));
    end
    chk("full_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_x = 11'd639; wr_y = 11'd15; wr_color = 12'h7E7;
    repeat (3) tick();
    chk("full_hold", 32'(wr_ready), 32'd0);
    blank_in = 1'b1;
    send(11'd639, 11'd15, 12'h7E7);
    send(11'd700, 11'd5, 12'hEEE);
    send(11'd5, 11'd16, 12'hDDD);
    send(11'd640, 11'd0, 12'hCCC);
    wait_drain("drain_fifo");
    chk("drain_ready", 32'(wr_ready), 32'd1);
`ifdef FB_DROP_COUNT_EN
    chk("drop_count", 32'(drop_count), 32'(n_drop));
`endif

    // full clear with blanking held; a FIFO write queued mid-clear lands last
    clear_color = 12'h00F; clear_req = 1'b1;
    for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), 12'h00F});
    tick();
    busy_cnt = 0;
    clear_req = 1'b0;
    chk("clr_busy", 32'(clear_busy), 32'd1);
    send(11'd20, 11'd3, 12'h0F0);
    clear_color = 12'hFFF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int n = 0; n < NPIX + 100 && clear_busy; n++) tick();
    chk("clr_done", 32'(clear_busy), 32'd0);
    chk("clr_len", 32'(busy_cnt), 32'(NPIX));
    wait_drain("drain_clear");

    // clear paused by active windows
    clear_color = 12'h0F0; clear_req = 1'b1;
    for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), 12'h0F0});
    tick();
    clear_req = 1'b0;
    for (int w = 0; w < 150 && clear_busy; w++) begin
      blank_in = 1'b1;
      repeat (100) tick();
      blank_in = 1'b0; drawX = 11'((w * 7) % TB_H); drawY = 11'(w % TB_V);
      repeat (100) tick();
    end
    blank_in = 1'b1;
    chk("pause_done", 32'(clear_busy), 32'd0);
    wait_drain("drain_pause");

    // reset mid-clear aborts it
    sb_en = 1'b0;
    clear_color = 12'h555; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wr_cnt = 0;
    repeat (50) tick();
    chk("midclr_running", 32'(wr_cnt != 0), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(clear_busy), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_busy", 32'(clear_busy), 32'd0);
    chk("post_we", 32'(mem_we), 32'd0);
    chk("post_bg", 32'(background), 32'd0);
    chk("post_ready", 32'(wr_ready), 32'd1);
    wr_cnt = 0;
    repeat (100) tick();
    chk("post_no_writes", 32'(wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
